// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller bus: pipeline status in, stall/flush controls out
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             i_mem_busy;
  logic             d_mem_busy;
  logic             ctx_req;
  logic             cache_swap_done;
  logic             pc_write;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             cache_swap_req;
  logic             ctx_ack;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline / context-switch side: supplies hazard status, consumes controls
  modport master (
    output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken,
           i_mem_busy, d_mem_busy, ctx_req, cache_swap_done,
    input  pc_write, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, cache_swap_req, ctx_ack, state, stall_cycles
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken,
           i_mem_busy, d_mem_busy, ctx_req, cache_swap_done,
    output pc_write, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, cache_swap_req, ctx_ack, state, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer with context-switch drain FSM
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWAP   = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic busy;
  logic load_use;
  logic accept;

  logic pc_write, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, cache_swap_req, ctx_ack;

  assign busy     = bus.i_mem_busy | bus.d_mem_busy;
  assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
  // A wrong-path branch in EX or a memory freeze would corrupt the drain, so wait them out
  assign accept   = (state_q == ST_RUN) && bus.ctx_req && armed_q && !busy && !bus.ex_branch_taken;

  // Control outputs: priority resolution in RUN/RESUME, fixed patterns while switching
  always_comb begin
    pc_write       = 1'b0;
    if_id_en       = 1'b0;
    id_ex_en       = 1'b0;
    ex_mem_en      = 1'b0;
    mem_wb_en      = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    cache_swap_req = 1'b0;
    ctx_ack        = 1'b0;
    case (state_q)
      ST_RUN, ST_RESUME: begin
        ctx_ack = (state_q == ST_RESUME);
        if (busy) begin
          // everything frozen
        end else if (bus.ex_branch_taken) begin
          {pc_write, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          {id_ex_en, ex_mem_en, mem_wb_en} = 3'b111;
          id_ex_flush = 1'b1;
        end else begin
          {pc_write, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
        end
      end
      ST_DRAIN: begin
        // ID holds its instruction; bubbles enter EX while the back end retires
        id_ex_flush = 1'b1;
        if (!bus.d_mem_busy) begin
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
        end
      end
      ST_SWAP: begin
        cache_swap_req = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write       = 1'b0;
      if_id_en       = 1'b0;
      id_ex_en       = 1'b0;
      ex_mem_en      = 1'b0;
      mem_wb_en      = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      cache_swap_req = 1'b0;
      ctx_ack        = 1'b0;
    end
  end

  // Next-state: switch sequencing, drain countdown, re-arm and stall counting
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    stall_d = stall_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          state_d = ST_DRAIN;
          cnt_d   = DW'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        if (!bus.d_mem_busy) begin
          cnt_d = cnt_q - DW'(1);
          if (cnt_q == DW'(1)) state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        if (bus.cache_swap_done) state_d = ST_RESUME;
      end
      ST_RESUME: begin
        state_d = ST_RUN;
        armed_d = 1'b0;
      end
      default: state_d = ST_RUN;
    endcase
    // A request still high after ack must be seen low before another switch
    if (!bus.ctx_req) armed_d = 1'b1;
    if ((state_q == ST_RUN || state_q == ST_RESUME) && !pc_write && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      stall_q <= stall_d;
    end
  end

  assign bus.pc_write       = pc_write;
  assign bus.if_id_en       = if_id_en;
  assign bus.id_ex_en       = id_ex_en;
  assign bus.ex_mem_en      = ex_mem_en;
  assign bus.mem_wb_en      = mem_wb_en;
  assign bus.if_id_flush    = if_id_flush;
  assign bus.id_ex_flush    = id_ex_flush;
  assign bus.cache_swap_req = cache_swap_req;
  assign bus.ctx_ack        = ctx_ack;
  assign bus.state          = state_q;
  assign bus.stall_cycles   = stall_q;

endmodule
